// File: rtl/caxi4interconnect_sync_fifo_ctrl.sv
// FIFO controller for a dual-port RAM with a 2-entry first-word-fall-through
// output buffer that hides the RAM read latency.
module caxi4interconnect_sync_fifo_ctrl #(
   parameter int HI_FREQ     = 1,
   parameter int FIFO_AWIDTH = 9,
   parameter int FIFO_WIDTH  = 8
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   input  logic                   wrValid,
   output logic                   wrReady,
   input  logic [FIFO_WIDTH-1:0]  wrData,
   output logic                   rdValid,
   input  logic                   rdReady,
   output logic [FIFO_WIDTH-1:0]  rdData,
   output logic [FIFO_AWIDTH-1:0] ramWrAddr,
   output logic                   ramWrite,
   output logic [FIFO_WIDTH-1:0]  ramWrData,
   output logic [FIFO_AWIDTH-1:0] ramRdAddr,
   input  logic [FIFO_WIDTH-1:0]  ramRdData,
   output logic [FIFO_AWIDTH+1:0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int PW = FIFO_AWIDTH + 1;
   localparam int CW = FIFO_AWIDTH + 2;
   localparam logic [PW-1:0] DEPTH = PW'(1) << FIFO_AWIDTH;

   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         ram_cnt;
   logic                  in_flight;
   logic [1:0]            out_cnt;
   logic [1:0]            pending;
   logic [FIFO_WIDTH-1:0] head;
   logic [FIFO_WIDTH-1:0] skid;
   logic                  push;
   logic                  pop;
   logic                  fetch;
   logic                  fill;

   assign ram_cnt = wr_ptr - rd_ptr;
   assign full    = (ram_cnt == DEPTH);
   assign wrReady = ~full & ~HRESET;
   assign push    = wrValid & wrReady;
   assign rdValid = (out_cnt != 2'd0);
   assign pop     = rdValid & rdReady;

   // Reserve a buffer slot for every beat already requested from the RAM.
   assign pending = out_cnt + 2'(in_flight) - 2'(pop);
   assign fetch   = (ram_cnt != '0) & (pending < 2'd2);
   assign fill    = (HI_FREQ != 0) ? in_flight : fetch;

   assign ramWrAddr = wr_ptr[FIFO_AWIDTH-1:0];
   assign ramRdAddr = rd_ptr[FIFO_AWIDTH-1:0];
   assign ramWrite  = push;
   assign ramWrData = wrData;
   assign rdData    = head;

   assign count = {1'b0, ram_cnt} + CW'(in_flight) + CW'(out_cnt);
   assign empty = (count == '0);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         in_flight <= 1'b0;
         out_cnt   <= 2'd0;
         head      <= '0;
         skid      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (fetch) rd_ptr <= rd_ptr + PW'(1);
         in_flight <= (HI_FREQ != 0) && fetch;
         case ({fill, pop})
            2'b10: begin
               if (out_cnt == 2'd0) head <= ramRdData;
               else skid <= ramRdData;
               out_cnt <= out_cnt + 2'd1;
            end
            2'b01: begin
               head    <= skid;
               out_cnt <= out_cnt - 2'd1;
            end
            2'b11: begin
               if (out_cnt == 2'd2) begin
                  head <= skid;
                  skid <= ramRdData;
               end else begin
                  head <= ramRdData;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
